// File: rtl/alarm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarm_pkg : shared field codes, ranges, key FSM states and BCD helper    |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package alarm_pkg;

  localparam logic [1:0] FIELD_MIN  = 2'b11;
  localparam logic [1:0] FIELD_HOUR = 2'b10;
  localparam int         MIN_MOD    = 60;
  localparam int         HOUR_MOD   = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] u;
    t = v / 7'd10;
    u = v % 7'd10;
    return {t[3:0], u[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_key_repeat.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarm_key_repeat : up/down key FSM with hold-to-autorepeat step pulses   |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module alarm_key_repeat
  import alarm_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic key_up_i,
  input  logic key_dn_i,
  output logic step_up_o,
  output logic step_dn_o
);

  localparam int c_cnt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_cnt_w-1:0] c_delay_last  = c_cnt_w'(REPEAT_DELAY - 1);
  localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(REPEAT_PERIOD - 1);

  key_state_e         state_q;
  logic [c_cnt_w-1:0] cnt_q;
  logic               dir_up_q;

  logic               w_active;
  logic [c_cnt_w-1:0] w_cnt_inc;

  assign w_active  = key_up_i ^ key_dn_i;
  assign w_cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_up_q  <= 1'b0;
      step_up_o <= 1'b0;
      step_dn_o <= 1'b0;
    end else begin
      step_up_o <= 1'b0;
      step_dn_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick_i && w_active) begin
            step_up_o <= key_up_i;
            step_dn_o <= key_dn_i;
            dir_up_q  <= key_up_i;
            cnt_q     <= '0;
            state_q   <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          // Release, chord or direction change drops back without stepping.
          if (!w_active || (key_up_i != dir_up_q)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (tick_i) begin
            if ((state_q == HOLD) ? (w_cnt_inc >= c_delay_last)
                                  : (cnt_q == c_period_last)) begin
              step_up_o <= dir_up_q;
              step_dn_o <= !dir_up_q;
              cnt_q     <= '0;
              state_q   <= REPEAT;
            end else begin
              cnt_q <= w_cnt_inc;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alarm_bank_editor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarm_bank_editor : NUM_ALARMS HH:MM alarms with editing, arm and ring   |
// | Option ALARM_SNOOZE_EN adds per-alarm snooze.  Revision : 1.0            |
// +--------------------------------------------------------------------------+
module alarm_bank_editor
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS    = 2,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10,
  parameter int SNOOZE_MIN    = 5,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  edit_en,
  input  logic [1:0]            field_sel,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  key_up,
  input  logic                  key_dn,
  input  logic                  arm_toggle,
  input  logic [4:0]            cur_hours,
  input  logic [5:0]            cur_minutes,
  input  logic                  minute_strobe,
  input  logic                  stop,
  input  logic                  snooze,
  output logic [15:0]           display_digits,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] ring
);

  logic [4:0] hours_q [NUM_ALARMS];
  logic [5:0] mins_q  [NUM_ALARMS];
  logic [4:0] hours_d;
  logic [5:0] mins_d;

  logic       w_step_up;
  logic       w_step_dn;
  logic       w_sel_valid;
  logic       w_edit;
  logic [4:0] w_cur_h;
  logic [5:0] w_cur_m;

  alarm_key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_key (
    .clk      (clk),
    .rst_n    (rst),
    .tick_i   (tick),
    .key_up_i (key_up),
    .key_dn_i (key_dn),
    .step_up_o(w_step_up),
    .step_dn_o(w_step_dn)
  );

  assign w_sel_valid = (32'(alarm_sel) < NUM_ALARMS);
  assign w_cur_h     = hours_q[alarm_sel];
  assign w_cur_m     = mins_q[alarm_sel];
  assign w_edit      = (w_step_up || w_step_dn) && edit_en && w_sel_valid &&
                       ((field_sel == FIELD_MIN) || (field_sel == FIELD_HOUR));

  // Fields wrap independently; no carry from minutes into hours.
  always_comb begin
    hours_d = w_cur_h;
    mins_d  = w_cur_m;
    if (w_step_up) begin
      hours_d = (w_cur_h == 5'(HOUR_MOD - 1)) ? 5'd0 : w_cur_h + 5'd1;
      mins_d  = (w_cur_m == 6'(MIN_MOD - 1))  ? 6'd0 : w_cur_m + 6'd1;
    end else begin
      hours_d = (w_cur_h == 5'd0) ? 5'(HOUR_MOD - 1) : w_cur_h - 5'd1;
      mins_d  = (w_cur_m == 6'd0) ? 6'(MIN_MOD - 1)  : w_cur_m - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        hours_q[i] <= '0;
        mins_q[i]  <= '0;
      end
    end else if (w_edit) begin
      if (field_sel == FIELD_MIN) mins_q[alarm_sel]  <= mins_d;
      else                        hours_q[alarm_sel] <= hours_d;
    end
  end

  assign display_digits = w_sel_valid ? {to_bcd({2'b00, w_cur_h}), to_bcd({1'b0, w_cur_m})}
                                      : 16'h0000;

`ifdef ALARM_SNOOZE_EN
  logic [6:0] w_snz_msum;
  logic [4:0] w_snz_h;
  logic [5:0] w_snz_m;

  always_comb begin
    w_snz_msum = {1'b0, cur_minutes} + 7'(SNOOZE_MIN);
    w_snz_h    = cur_hours;
    if (w_snz_msum >= 7'(MIN_MOD)) begin
      w_snz_msum = w_snz_msum - 7'(MIN_MOD);
      w_snz_h    = (cur_hours == 5'(HOUR_MOD - 1)) ? 5'd0 : cur_hours + 5'd1;
    end
    w_snz_m = w_snz_msum[5:0];
  end
`else
  logic w_unused_snooze;
  assign w_unused_snooze = snooze ^ (SNOOZE_MIN != 0);
`endif

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    logic armed_q;
    logic ring_q;
    logic w_arm_hit;
    logic w_match;
    logic w_clr;

    assign w_arm_hit = arm_toggle && w_sel_valid && (32'(alarm_sel) == i);
    assign w_match   = minute_strobe && armed_q &&
                       (hours_q[i] == cur_hours) && (mins_q[i] == cur_minutes);
    assign w_clr     = stop || (w_arm_hit && armed_q);
    assign armed[i]  = armed_q;
    assign ring[i]   = ring_q;

`ifdef ALARM_SNOOZE_EN
    logic       snz_act_q;
    logic [4:0] snz_h_q;
    logic [5:0] snz_m_q;
    logic       w_snz_match;
    logic       w_snz_take;

    assign w_snz_match = minute_strobe && snz_act_q &&
                         (snz_h_q == cur_hours) && (snz_m_q == cur_minutes);
    assign w_snz_take  = snooze && ring_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        armed_q   <= 1'b0;
        ring_q    <= 1'b0;
        snz_act_q <= 1'b0;
        snz_h_q   <= '0;
        snz_m_q   <= '0;
      end else begin
        if (w_arm_hit) armed_q <= !armed_q;
        if (w_clr) begin
          ring_q    <= 1'b0;
          snz_act_q <= 1'b0;
        end else if (w_snz_take) begin
          ring_q    <= 1'b0;
          snz_act_q <= 1'b1;
          snz_h_q   <= w_snz_h;
          snz_m_q   <= w_snz_m;
        end else if (w_snz_match) begin
          ring_q    <= 1'b1;
          snz_act_q <= 1'b0;
        end else if (w_match) begin
          ring_q <= 1'b1;
        end
      end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        armed_q <= 1'b0;
        ring_q  <= 1'b0;
      end else begin
        if (w_arm_hit) armed_q <= !armed_q;
        if (w_clr)        ring_q <= 1'b0;
        else if (w_match) ring_q <= 1'b1;
      end
    end
`endif
  end

endmodule
`default_nettype wire
